// File: rtl/mby_igr_shim_seg_sched.sv
// mby_igr_shim_seg_sched: per-port segment staging tracker and 2-slot round-robin PB write grant scheduler
// Ports: cclk/rst_n (sync, active-low); i_push_v 3 valids per port; i_pb_stall blocks grants;
// o_gnt_v/o_gnt_port/o_gnt_rptr two registered grant slots; o_xoff per-port threshold backpressure;
// o_ovf sticky drop flag; o_gnt_cnt saturating per-port grant counters, built only when
// MBY_IGR_SHIM_SCHED_STATS_EN is defined (tied to 0 otherwise).
module mby_igr_shim_seg_sched #(
  parameter int NUM_PORTS = 4,
  parameter int DEPTH = 16,
  parameter int XOFF_THR = 10,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   cclk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS*3-1:0] i_push_v,
  input  logic                   i_pb_stall,
  output logic [1:0]             o_gnt_v,
  output logic [3:0]             o_gnt_port,
  output logic [2*AW-1:0]        o_gnt_rptr,
  output logic [NUM_PORTS-1:0]   o_xoff,
  output logic [NUM_PORTS-1:0]   o_ovf,
  output logic [NUM_PORTS*32-1:0] o_gnt_cnt
);
  logic [AW:0]   occ    [NUM_PORTS];
  logic [AW-1:0] rptr   [NUM_PORTS];
  logic [1:0]    push_n [NUM_PORTS];
  logic [1:0]    pop    [NUM_PORTS];
  logic [AW:0]   acc    [NUM_PORTS];
  logic [1:0]    rr;
  logic          g0, g1;
  logic [1:0]    p0, p1;
  logic [AW-1:0] r0, r1;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      push_n[p] = {1'b0, i_push_v[3*p]} + {1'b0, i_push_v[3*p+1]} + {1'b0, i_push_v[3*p+2]};
      acc[p] = ((AW+1)'(push_n[p]) > (AW+1)'(DEPTH) - occ[p]) ? (AW+1)'(DEPTH) - occ[p] : (AW+1)'(push_n[p]);
    end
  end

  // Searches run downward so the last hit, i.e. the nearest port to the start, wins.
  always_comb begin
    g0 = 1'b0;
    p0 = '0;
    g1 = 1'b0;
    p1 = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--)
      if (occ[rr + 2'(i)] != '0) begin
        g0 = 1'b1;
        p0 = rr + 2'(i);
      end
    for (int i = NUM_PORTS - 1; i >= 1; i--)
      if (occ[p0 + 2'(i)] != '0) begin
        g1 = 1'b1;
        p1 = p0 + 2'(i);
      end
    if (!g1 && occ[p0] >= (AW+1)'(2)) begin
      g1 = 1'b1;
      p1 = p0;
    end
    if (i_pb_stall || !g0) begin
      g0 = 1'b0;
      g1 = 1'b0;
      p0 = '0;
      p1 = '0;
    end
    r0 = rptr[p0];
    r1 = (p1 == p0) ? rptr[p0] + AW'(1) : rptr[p1];
    for (int p = 0; p < NUM_PORTS; p++)
      pop[p] = 2'(g0 && p0 == 2'(p)) + 2'(g1 && p1 == 2'(p));
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        occ[p] <= '0;
        rptr[p] <= '0;
      end
      rr <= '0;
      o_gnt_v <= '0;
      o_gnt_port <= '0;
      o_gnt_rptr <= '0;
      o_xoff <= '0;
      o_ovf <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        occ[p] <= occ[p] + acc[p] - (AW+1)'(pop[p]);
        rptr[p] <= rptr[p] + AW'(pop[p]);
        o_xoff[p] <= occ[p] >= (AW+1)'(XOFF_THR);
        if ((AW+1)'(push_n[p]) > acc[p]) o_ovf[p] <= 1'b1;
      end
      if (g0) rr <= (g1 ? p1 : p0) + 2'd1;
      o_gnt_v <= {g1, g0};
      o_gnt_port <= {p1, p0};
      o_gnt_rptr <= {g1 ? r1 : {AW{1'b0}}, g0 ? r0 : {AW{1'b0}}};
    end
  end

`ifdef MBY_IGR_SHIM_SCHED_STATS_EN
  logic [31:0] cnt [NUM_PORTS];
  always_ff @(posedge cclk) begin
    for (int p = 0; p < NUM_PORTS; p++)
      if (!rst_n) cnt[p] <= '0;
      else cnt[p] <= (cnt[p] > 32'hFFFF_FFFF - 32'(pop[p])) ? 32'hFFFF_FFFF : cnt[p] + 32'(pop[p]);
  end
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign o_gnt_cnt[32*g +: 32] = cnt[g];
  end
`else
  assign o_gnt_cnt = '0;
`endif
endmodule
